// File: rtl/line_mem_resp.sv
// line_mem_resp: main-memory responder behind the L1i/L1d line buses.
// One transaction in flight at a time, round-robin between the instruction
// and data ports, fixed latency from grant to a one-cycle done pulse.
module line_mem_resp #(
    parameter int LINE_W    = 256,
    parameter int DEPTH     = 1024,
    parameter int LAT       = 4,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       b_addr_i,
    input  logic              b_rd_i,
    output logic [LINE_W-1:0] b_data_i,
    output logic              b_dv_i,
    input  logic [63:0]       b_addr,
    input  logic              b_rd,
    input  logic              b_wr,
    input  logic [LINE_W-1:0] b_data_out,
    output logic [LINE_W-1:0] b_data_in,
    output logic              b_dv
);

    localparam int OFFS = $clog2(LINE_W / 8);
    localparam int IDX  = $clog2(DEPTH);
    localparam int CW   = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Transaction latched at grant; later address/data changes are ignored.
    typedef struct packed {
        logic           port_d;   // 1 = data port, 0 = instruction port
        logic           wr;       // data-port write
        logic [IDX-1:0] idx;
    } req_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic              last_d;    // last served port was the data port
    req_t              req_q;
    logic              gnt_i, gnt_d, fire;
    logic              req_i, req_d;
    logic [IDX-1:0]    idx_i, idx_d;
    logic [LINE_W-1:0] mem [DEPTH];

    assign req_i = b_rd_i;
    assign req_d = b_rd | b_wr;
    assign idx_i = b_addr_i[OFFS+IDX-1:OFFS];
    assign idx_d = b_addr[OFFS+IDX-1:OFFS];

    // Offset and upper address bits alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{b_addr_i[63:OFFS+IDX], b_addr_i[OFFS-1:0],
                                b_addr[63:OFFS+IDX], b_addr[OFFS-1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt_i || gnt_d) state_nx = BUSY;
            BUSY:    if (cnt == '0)      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant/fire decode; on a tie the port not served last wins.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        fire  = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    gnt_d = req_d && (!req_i || !last_d);
                    gnt_i = req_i && !gnt_d;
                end
            end
            BUSY:    fire = (cnt == '0);
            default: ;
        endcase
    end

    // Latch request at grant, count down latency, drive completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            last_d    <= 1'b0;
            req_q     <= '0;
            b_dv      <= 1'b0;
            b_dv_i    <= 1'b0;
            b_data_in <= '0;
            b_data_i  <= '0;
        end else begin
            b_dv   <= 1'b0;
            b_dv_i <= 1'b0;
            if (gnt_i || gnt_d) begin
                req_q.port_d <= gnt_d;
                req_q.wr     <= gnt_d && b_wr;
                req_q.idx    <= gnt_d ? idx_d : idx_i;
                cnt          <= CW'(LAT - 1);
                last_d       <= gnt_d;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (fire) begin
                if (req_q.port_d) begin
                    b_dv <= 1'b1;
                    if (!req_q.wr) b_data_in <= mem[req_q.idx];
                end else begin
                    b_dv_i   <= 1'b1;
                    b_data_i <= mem[req_q.idx];
                end
            end
        end
    end

    // Writes commit at the grant edge, so a reset afterwards cannot undo them.
    always_ff @(posedge clk) begin
        if (gnt_d && b_wr) mem[idx_d] <= b_data_out;
    end

endmodule

// File: tb/tb_line_mem_resp.sv
// tb_line_mem_resp: scoreboard bench for line_mem_resp (LAT=4, 256-bit lines).
module tb_line_mem_resp;

    localparam int LINE_W = 256;
    localparam int DEPTH  = 1024;
    localparam int LAT    = 4;
    localparam int OFFS   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       b_addr_i, b_addr;
    logic              b_rd_i, b_rd, b_wr;
    logic [LINE_W-1:0] b_data_i, b_data_in, b_data_out;
    logic              b_dv_i, b_dv;

    int vectors     = 0;
    int miscompares = 0;

    logic [LINE_W-1:0] exp_d[$];
    logic [LINE_W-1:0] exp_i[$];
    logic [LINE_W-1:0] model[int];
    logic [LINE_W-1:0] last_din, last_di;
    logic [LINE_W-1:0] pat, p11;

    line_mem_resp #(.LINE_W(LINE_W), .DEPTH(DEPTH), .LAT(LAT), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .b_addr_i(b_addr_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i), .b_dv_i(b_dv_i),
        .b_addr(b_addr), .b_rd(b_rd), .b_wr(b_wr), .b_data_out(b_data_out),
        .b_data_in(b_data_in), .b_dv(b_dv)
    );

    always #5 clk = ~clk;

    function automatic int lidx(input logic [63:0] a);
        return int'((a >> OFFS) & 64'(DEPTH - 1));
    endfunction

    function automatic logic [LINE_W-1:0] mread(input logic [63:0] a);
        if (model.exists(lidx(a))) return model[lidx(a)];
        return '0;
    endfunction

    // Counts edges until the selected port's dv, noting any dv on the other port.
    task automatic wait_dv(input bit port_d, output int n, output bit other);
        n = 0;
        other = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (port_d ? b_dv_i : b_dv) other = 1;
        end while (!(port_d ? b_dv : b_dv_i) && n < 40);
    endtask

    // One data-port transaction; caller is at posedge+1 with the DUT idle.
    task automatic run_d(input logic [63:0] addr, input bit rd, input bit wr,
                         input logic [LINE_W-1:0] wd, input bit drop);
        int n;
        bit oth;
        logic [LINE_W-1:0] e;
        if (wr) begin
            model[lidx(addr)] = wd;
            exp_d.push_back(last_din);
        end else begin
            e = mread(addr);
            exp_d.push_back(e);
            last_din = e;
        end
        b_addr = addr; b_rd = rd; b_wr = wr; b_data_out = wd;
        @(posedge clk); #1;
        if (drop) begin
            b_rd = 0; b_wr = 0; b_addr = ~addr; b_data_out = ~wd;
        end
        wait_dv(1, n, oth);
        vectors++;
        if (n != LAT) begin
            miscompares++;
            $display("FAIL d_latency addr=%h got %0d cycles exp %0d", addr, n, LAT);
        end
        vectors++;
        if (oth) begin
            miscompares++;
            $display("FAIL d_cross addr=%h got b_dv_i=1 exp 0", addr);
        end
        if (exp_d.size() > 0) begin
            e = exp_d.pop_front();
            vectors++;
            if (b_data_in !== e) begin
                miscompares++;
                $display("FAIL d_data addr=%h got %h exp %h", addr, b_data_in, e);
            end
        end
        b_rd = 0; b_wr = 0;
        @(posedge clk); #1;
        vectors++;
        if (b_dv !== 1'b0) begin
            miscompares++;
            $display("FAIL d_pulse addr=%h got b_dv=%b exp 0", addr, b_dv);
        end
    endtask

    // One instruction-port read; caller is at posedge+1 with the DUT idle.
    task automatic run_i(input logic [63:0] addr);
        int n;
        bit oth;
        logic [LINE_W-1:0] e;
        e = mread(addr);
        exp_i.push_back(e);
        last_di = e;
        b_addr_i = addr; b_rd_i = 1;
        @(posedge clk); #1;
        wait_dv(0, n, oth);
        vectors++;
        if (n != LAT) begin
            miscompares++;
            $display("FAIL i_latency addr=%h got %0d cycles exp %0d", addr, n, LAT);
        end
        vectors++;
        if (oth) begin
            miscompares++;
            $display("FAIL i_cross addr=%h got b_dv=1 exp 0", addr);
        end
        if (exp_i.size() > 0) begin
            e = exp_i.pop_front();
            vectors++;
            if (b_data_i !== e) begin
                miscompares++;
                $display("FAIL i_data addr=%h got %h exp %h", addr, b_data_i, e);
            end
        end
        b_rd_i = 0;
        @(posedge clk); #1;
        vectors++;
        if (b_dv_i !== 1'b0) begin
            miscompares++;
            $display("FAIL i_pulse addr=%h got b_dv_i=%b exp 0", addr, b_dv_i);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1; b_rd_i = 0; b_rd = 0; b_wr = 0;
        repeat (cycles) @(posedge clk);
        #1 rst = 0;
        last_din = '0;
        last_di  = '0;
    endtask

    task automatic test_reset();
        b_addr_i = '0; b_addr = '0; b_data_out = '0;
        do_reset(3);
        vectors++;
        if (b_dv !== 1'b0 || b_dv_i !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dv got b_dv=%b b_dv_i=%b exp 0 0", b_dv, b_dv_i);
        end
        vectors++;
        if (b_data_in !== '0) begin
            miscompares++;
            $display("FAIL reset_data_in got %h exp 0", b_data_in);
        end
        vectors++;
        if (b_data_i !== '0) begin
            miscompares++;
            $display("FAIL reset_data_i got %h exp 0", b_data_i);
        end
    endtask

    task automatic test_write_read();
        run_d(64'h40, 0, 1, pat, 0);
        run_d(64'h40, 1, 0, '0, 0);
    endtask

    task automatic test_instr_read();
        run_i(64'h40);
    endtask

    // Simultaneous requests after reset: data wins, instruction follows at T+6.
    task automatic test_tie();
        int n1, n2;
        bit o1, o2;
        logic [LINE_W-1:0] e;
        do_reset(1);
        exp_d.push_back(mread(64'h40));
        exp_i.push_back(mread(64'h40));
        last_din = mread(64'h40);
        last_di  = mread(64'h40);
        b_addr = 64'h40; b_addr_i = 64'h40; b_rd = 1; b_rd_i = 1;
        @(posedge clk); #1;
        wait_dv(1, n1, o1);
        b_rd = 0;
        vectors++;
        if (n1 != LAT || o1) begin
            miscompares++;
            $display("FAIL tie_data_first got n=%0d cross=%b exp n=%0d cross=0", n1, o1, LAT);
        end
        e = exp_d.pop_front();
        vectors++;
        if (b_data_in !== e) begin
            miscompares++;
            $display("FAIL tie_data got %h exp %h", b_data_in, e);
        end
        wait_dv(0, n2, o2);
        b_rd_i = 0;
        vectors++;
        if (n2 != LAT + 2 || o2) begin
            miscompares++;
            $display("FAIL tie_instr_next got n=%0d cross=%b exp n=%0d cross=0", n2, o2, LAT + 2);
        end
        e = exp_i.pop_front();
        vectors++;
        if (b_data_i !== e) begin
            miscompares++;
            $display("FAIL tie_instr_data got %h exp %h", b_data_i, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alias();
        run_d(64'h47, 1, 0, '0, 0);
        run_d(64'h40 + 64'(DEPTH * LINE_W / 8), 1, 0, '0, 0);
        run_i(64'h5F);
    endtask

    // Reset two cycles into a read abandons it; the next read has full latency.
    task automatic test_mid_reset();
        bit seen = 0;
        b_addr = 64'h40; b_rd = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; b_rd = 0;
        @(posedge clk); #1;
        rst = 0;
        last_din = '0;
        last_di  = '0;
        repeat (LAT + 3) begin
            if (b_dv || b_dv_i) seen = 1;
            @(posedge clk); #1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL midrst_no_dv got dv=1 exp 0");
        end
        vectors++;
        if (b_data_in !== '0) begin
            miscompares++;
            $display("FAIL midrst_data got %h exp 0", b_data_in);
        end
        run_d(64'h40, 1, 0, '0, 0);
    endtask

    task automatic test_rdwr();
        run_d(64'h80, 1, 1, p11, 0);
        run_d(64'h80, 1, 0, '0, 0);
        run_i(64'h80);
    endtask

    // Dropped write with address/data scrambled after grant still commits as latched.
    task automatic test_drop();
        logic [LINE_W-1:0] v;
        v = {4{64'h0123_4567_89AB_CDEF}};
        run_d(64'hC0, 0, 1, v, 1);
        run_d(64'hC0, 1, 0, '0, 0);
        run_i(64'hC0);
    endtask

    // Alternating ports back to back with varied data.
    task automatic test_back_to_back();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < 4; k++) begin
            v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_d(64'(k * 32 + 256), 0, 1, v, 0);
            run_i(64'(k * 32 + 256));
        end
        for (int k = 0; k < 4; k++) run_d(64'(k * 32 + 256), 1, 0, '0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        pat = {4{64'hA5A5_0000_DEAD_BEEF}};
        p11 = {32{8'h11}};
        test_reset();
        test_write_read();
        test_instr_read();
        test_tie();
        test_alias();
        test_mid_reset();
        test_rdwr();
        test_drop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
